controle_rega: RTL and testbench

//  Upstream controller for the irrigation display stage. Debounces the raw tank-level and climate sensors.

---
 rtl/controle_rega_pkg.sv | 14 +
 rtl/controle_rega_filtro_sensor.sv | 25 ++
 rtl/controle_rega.sv | 78 +++++++
 tb/tb_controle_rega.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/controle_rega_pkg.sv
// controle_rega_pkg: irrigation FSM states, valid tank-level patterns and shared helpers
package controle_rega_pkg;
    typedef enum logic [2:0] {INICIO, OCIOSO, ENCHENDO, ASPERSAO, GOTEJAMENTO, PAUSA, ERRO} estado_t;
    localparam logic [2:0] NIVEL_VAZIO = 3'b000;
    localparam logic [2:0] NIVEL_BAIXO = 3'b001;
    localparam logic [2:0] NIVEL_MEDIO = 3'b011;
    localparam logic [2:0] NIVEL_CHEIO = 3'b111;
    function automatic logic nivel_valido(input logic [2:0] hml);
        return hml == NIVEL_VAZIO || hml == NIVEL_BAIXO || hml == NIVEL_MEDIO || hml == NIVEL_CHEIO;
    endfunction
    function automatic int maior(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/controle_rega_filtro_sensor.sv
// controle_rega_filtro_sensor: one-bit debouncer that follows raw after DEB_CYCLES consecutive differing samples
module controle_rega_filtro_sensor #(
    parameter int DEB_CYCLES = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw,
    output logic q
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            q   <= 1'b0;
            cnt <= '0;
        end else if (raw == q) begin
            cnt <= '0;
        end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            q   <= raw;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/controle_rega.sv
// controle_rega: debounced sensors, irrigation FSM with shared saturating timer and registered actuator outputs
module controle_rega
    import controle_rega_pkg::*;
#(
    parameter int DEB_CYCLES   = 4,
    parameter int FILL_TIMEOUT = 1000,
    parameter int IRR_MAX      = 500,
    parameter int IRR_PAUSE    = 200
) (
    input  logic Clk,
    input  logic Reset,
    input  logic H_raw,
    input  logic M_raw,
    input  logic L_raw,
    input  logic Us_raw,
    input  logic T_raw,
    input  logic Ack,
    output logic H,
    output logic M,
    output logic L,
    output logic Bs,
    output logic Vs,
    output logic Sd,
    output logic Ve,
    output logic Alarm
);
    localparam int T_MAX = maior(maior(FILL_TIMEOUT, IRR_MAX), maior(IRR_PAUSE, DEB_CYCLES + 1));
    localparam int TW = $clog2(T_MAX + 1);
    logic [4:0] bruto, limpo;
    logic us, t, nivel_ok;
    logic [TW-1:0] timer;
    estado_t estado, prox;
    assign bruto = {H_raw, M_raw, L_raw, Us_raw, T_raw};
    for (genvar i = 0; i < 5; i++) begin : g_filtro
        controle_rega_filtro_sensor #(.DEB_CYCLES(DEB_CYCLES)) u_filtro (
            .Clk  (Clk),
            .Reset(Reset),
            .raw  (bruto[i]),
            .q    (limpo[i])
        );
    end
    assign {H, M, L, us, t} = limpo;
    assign nivel_ok = nivel_valido({H, M, L});
    always_comb begin
        prox = estado;
        case (estado)
            INICIO:                prox = timer == TW'(DEB_CYCLES) ? OCIOSO : INICIO;
            OCIOSO:                prox = !nivel_ok ? ERRO : !L ? ENCHENDO : us ? OCIOSO :
                                          (!M || t) ? GOTEJAMENTO : ASPERSAO;
            ENCHENDO:              prox = !nivel_ok ? ERRO : H ? OCIOSO :
                                          timer == TW'(FILL_TIMEOUT - 1) ? ERRO : ENCHENDO;
            ASPERSAO, GOTEJAMENTO: prox = !nivel_ok ? ERRO : !L ? ENCHENDO : us ? OCIOSO :
                                          timer == TW'(IRR_MAX - 1) ? PAUSA : estado;
            PAUSA:                 prox = !nivel_ok ? ERRO : timer == TW'(IRR_PAUSE - 1) ? OCIOSO : PAUSA;
            ERRO:                  prox = (Ack && nivel_ok) ? OCIOSO : ERRO;
            default:               prox = INICIO;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            estado <= INICIO;
            timer  <= '0;
            Bs     <= 1'b0;
            Vs     <= 1'b0;
            Sd     <= 1'b0;
            Ve     <= 1'b0;
            Alarm  <= 1'b0;
        end else begin
            estado <= prox;
            timer  <= prox != estado ? '0 : timer == TW'(T_MAX) ? timer : timer + 1'b1;
            Bs     <= estado == ASPERSAO;
            Vs     <= estado == GOTEJAMENTO;
            Sd     <= estado == ASPERSAO || estado == GOTEJAMENTO;
            Ve     <= estado == ENCHENDO;
            Alarm  <= estado == ERRO;
        end
    end
endmodule

// File: tb/tb_controle_rega.sv
// tb_controle_rega: randomized and directed stimulus against a cycle-level reference model with a scoreboard queue
module tb_controle_rega;
    localparam int DEB = 4;
    localparam int FILL = 50;
    localparam int IMAX = 20;
    localparam int IPAUSE = 10;
    logic Clk = 1'b0, Reset = 1'b1;
    logic H_raw = 1'b0, M_raw = 1'b0, L_raw = 1'b0, Us_raw = 1'b1, T_raw = 1'b0, Ack = 1'b0;
    logic H, M, L, Bs, Vs, Sd, Ve, Alarm;
    int n_cmp = 0, n_err = 0;
    logic [7:0] sb[$];
    string nm[8] = '{"Alarm", "Ve", "Sd", "Vs", "Bs", "L", "M", "H"};
    bit m_db[5];
    int m_cnt[5];
    string m_st = "INICIO";
    int m_spent = 0;
    bit [4:0] o_act = '0;

    controle_rega #(.DEB_CYCLES(DEB), .FILL_TIMEOUT(FILL), .IRR_MAX(IMAX), .IRR_PAUSE(IPAUSE)) dut (
        .Clk(Clk), .Reset(Reset), .H_raw(H_raw), .M_raw(M_raw), .L_raw(L_raw), .Us_raw(Us_raw),
        .T_raw(T_raw), .Ack(Ack), .H(H), .M(M), .L(L), .Bs(Bs), .Vs(Vs), .Sd(Sd), .Ve(Ve), .Alarm(Alarm)
    );

    always #5 Clk = ~Clk;

    task automatic model_step();
        bit raw[5];
        string nx;
        int lv;
        bit ok;
        raw = '{H_raw, M_raw, L_raw, Us_raw, T_raw};
        if (Reset) begin
            for (int i = 0; i < 5; i++) begin
                m_db[i] = 0;
                m_cnt[i] = 0;
            end
            m_st = "INICIO";
            m_spent = 0;
            o_act = '0;
        end else begin
            lv = 4 * int'(m_db[0]) + 2 * int'(m_db[1]) + int'(m_db[2]);
            ok = lv == 0 || lv == 1 || lv == 3 || lv == 7;
            nx = m_st;
            m_spent++;
            if (m_st == "INICIO") begin
                if (m_spent == DEB + 1) nx = "OCIOSO";
            end else if (m_st == "OCIOSO") begin
                if (!ok) nx = "ERRO";
                else if (!m_db[2]) nx = "ENCHENDO";
                else if (!m_db[3] && !m_db[1]) nx = "GOTEJAMENTO";
                else if (!m_db[3]) nx = m_db[4] ? "GOTEJAMENTO" : "ASPERSAO";
            end else if (m_st == "ENCHENDO") begin
                if (!ok) nx = "ERRO";
                else if (m_db[0]) nx = "OCIOSO";
                else if (m_spent == FILL) nx = "ERRO";
            end else if (m_st == "ASPERSAO" || m_st == "GOTEJAMENTO") begin
                if (!ok) nx = "ERRO";
                else if (!m_db[2]) nx = "ENCHENDO";
                else if (m_db[3]) nx = "OCIOSO";
                else if (m_spent == IMAX) nx = "PAUSA";
            end else if (m_st == "PAUSA") begin
                if (!ok) nx = "ERRO";
                else if (m_spent == IPAUSE) nx = "OCIOSO";
            end else if (m_st == "ERRO") begin
                if (Ack && ok) nx = "OCIOSO";
            end
            o_act = {m_st == "ASPERSAO", m_st == "GOTEJAMENTO",
                     m_st == "ASPERSAO" || m_st == "GOTEJAMENTO", m_st == "ENCHENDO", m_st == "ERRO"};
            if (nx != m_st) m_spent = 0;
            m_st = nx;
            for (int i = 0; i < 5; i++) begin
                if (raw[i] == m_db[i]) m_cnt[i] = 0;
                else if (++m_cnt[i] == DEB) begin
                    m_db[i] = raw[i];
                    m_cnt[i] = 0;
                end
            end
        end
        sb.push_back({m_db[0], m_db[1], m_db[2], o_act});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
            model_step();
        end
    endtask

    task automatic set_lvl(input logic [2:0] hml);
        {H_raw, M_raw, L_raw} = hml;
    endtask

    initial begin
        logic [7:0] exp_v, act_v;
        forever begin
            @(negedge Clk);
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                act_v = {H, M, L, Bs, Vs, Sd, Ve, Alarm};
                for (int i = 0; i < 8; i++) begin
                    n_cmp++;
                    if (act_v[i] !== exp_v[i]) begin
                        n_err++;
                        $display("FAIL %s @%0t: got %b expected %b", nm[i], $time, act_v[i], exp_v[i]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        Reset = 1'b0;
        set_lvl(3'b000); Us_raw = 1'b1; T_raw = 1'b0;
        tick(10);
        set_lvl(3'b001); tick(6);
        set_lvl(3'b011); tick(6);
        set_lvl(3'b111); tick(8);
        Us_raw = 1'b0; tick(10);
        Us_raw = 1'b1; tick(10);
        Us_raw = 1'b0; T_raw = 1'b1; tick(8);
        repeat (12) begin
            T_raw = ~T_raw;
            tick(3);
        end
        tick(10);
        Us_raw = 1'b1; T_raw = 1'b0; tick(8);
        Us_raw = 1'b0; tick(8);
        L_raw = 1'b0; tick(3);
        L_raw = 1'b1; tick(6);
        L_raw = 1'b0; tick(4);
        L_raw = 1'b1; tick(6);
        Ack = 1'b1; tick(3);
        Ack = 1'b0; Us_raw = 1'b1; tick(4);
        set_lvl(3'b101); tick(6);
        Ack = 1'b1; tick(3);
        set_lvl(3'b111); tick(8);
        Ack = 1'b0;
        set_lvl(3'b000); tick(60);
        Ack = 1'b1; tick(6);
        Ack = 1'b0; tick(6);
        set_lvl(3'b111); Us_raw = 1'b0; tick(16);
        Reset = 1'b1; tick(1);
        Reset = 1'b0; tick(12);
        repeat (3000) begin
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 9))
                    0: set_lvl(3'($urandom));
                    1, 2: set_lvl(3'b000);
                    3, 4: set_lvl(3'b001);
                    5, 6: set_lvl(3'b011);
                    default: set_lvl(3'b111);
                endcase
            end
            if ($urandom_range(0, 15) == 0) Us_raw = ~Us_raw;
            if ($urandom_range(0, 9) == 0) T_raw = ~T_raw;
            Ack = $urandom_range(0, 5) == 0;
            Reset = $urandom_range(0, 599) == 0;
            tick(1);
        end
        Reset = 1'b0;
        @(negedge Clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
